// File: rtl/tree_up_port_sched_if.sv
// Up-link scheduler bundle: child-side requests in, grant/status out.
//   master : drives req/head/tail/credit_in, observes grant and status
//   slave  : the scheduler itself
//   req/head/tail [K]  per-child flit presence and framing
//   credit_in          parent returned one buffer slot
//   grant [K]          one-hot grant (combinational)
//   out_valid          a flit crosses the up-link this cycle
//   out_sel [Kw]       binary index of the granted child
//   credits [Bw]       registered credit count
//   locked             registered, packet lock held
//   err                sticky protocol error
interface tree_up_port_sched_if #(
    parameter int K = 2,
    parameter int B = 4
);
    localparam int Kw = (K > 1) ? $clog2(K) : 1;
    localparam int Bw = $clog2(B + 1);

    logic [K-1:0]  req;
    logic [K-1:0]  head;
    logic [K-1:0]  tail;
    logic          credit_in;
    logic [K-1:0]  grant;
    logic          out_valid;
    logic [Kw-1:0] out_sel;
    logic [Bw-1:0] credits;
    logic          locked;
    logic          err;

    modport master (
        output req, head, tail, credit_in,
        input  grant, out_valid, out_sel, credits, locked, err
    );

    modport slave (
        input  req, head, tail, credit_in,
        output grant, out_valid, out_sel, credits, locked, err
    );
endinterface

// File: rtl/tree_up_port_sched.sv
// Packet-granularity round-robin scheduler for the up-link of a tree router.
// K children share the link; a head flit wins arbitration and holds the
// link until its tail flit. Every transfer consumes one credit mirroring a
// free slot in the parent's input buffer.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low
//   bus    : tree_up_port_sched_if.slave (requests in, grant/status out)
module tree_up_port_sched #(
    parameter int K = 2,
    parameter int B = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    tree_up_port_sched_if.slave  bus
);
    localparam int Kw = (K > 1) ? $clog2(K) : 1;
    localparam int Bw = $clog2(B + 1);
    localparam logic [Bw-1:0] CRED_MAX = Bw'(B);

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [Kw-1:0] ptr_q, ptr_d;
    logic [Kw-1:0] owner_q, owner_d;
    logic [Bw-1:0] credits_q, credits_d;
    logic          err_q, err_d;

    logic [K-1:0]  head_req;
    logic [K-1:0]  body_req;
    logic [K-1:0]  grant;
    logic [Kw-1:0] winner;
    logic [Kw-1:0] out_sel;
    logic          fire;
    logic          credit_ok;

    assign credit_ok = (credits_q != '0);

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_req
            assign head_req[gi] = bus.req[gi] &  bus.head[gi];
            assign body_req[gi] = bus.req[gi] & ~bus.head[gi];
        end
    endgenerate

    function automatic logic [Kw-1:0] rr_next(input logic [Kw-1:0] i);
        if (int'(i) == K - 1) return '0;
        return i + Kw'(1);
    endfunction

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            credits_q <= CRED_MAX;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    // Output logic: grant is combinational from registered state and inputs.
    // It is forced low while reset is held so nothing fires during reset.
    always_comb begin
        logic          found;
        logic [Kw-1:0] idx;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        if (reset) begin
            if (state_q == IDLE) begin
                if (credit_ok) begin
                    // Search starting at the pointer, wrapping mod K.
                    for (int off = 0; off < K; off++) begin
                        idx = Kw'((int'(ptr_q) + off) % K);
                        if (!found && head_req[idx]) begin
                            found  = 1'b1;
                            winner = idx;
                        end
                    end
                end
                if (found) grant[winner] = 1'b1;
            end else begin
                // Only the owner's body/tail flits may pass; a stray head
                // from the owner is a protocol error and is withheld.
                grant[owner_q] = body_req[owner_q] & credit_ok;
            end
        end
    end

    always_comb begin
        out_sel = '0;
        for (int i = 0; i < K; i++) begin
            if (grant[i]) out_sel = out_sel | Kw'(i);
        end
    end

    assign fire = |grant;

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        credits_d = credits_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (fire) begin
                    if (bus.tail[winner]) begin
                        ptr_d = rr_next(winner);
                    end else begin
                        state_d = LOCK;
                        owner_d = winner;
                    end
                end
                if (|body_req) err_d = 1'b1;
            end
            LOCK: begin
                if (fire && bus.tail[owner_q]) begin
                    state_d = IDLE;
                    ptr_d   = rr_next(owner_q);
                end
                if (head_req[owner_q]) err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (fire && !bus.credit_in) begin
            credits_d = credits_q - Bw'(1);
        end else if (bus.credit_in && !fire) begin
            if (credits_q == CRED_MAX) err_d = 1'b1;
            else                       credits_d = credits_q + Bw'(1);
        end
    end

    assign bus.grant     = grant;
    assign bus.out_valid = fire;
    assign bus.out_sel   = out_sel;
    assign bus.credits   = credits_q;
    assign bus.locked    = (state_q == LOCK);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_tree_up_port_sched.sv
module tb_tree_up_port_sched;
    localparam int K = 2;
    localparam int B = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    tree_up_port_sched_if #(.K(K), .B(B)) bus ();

    tree_up_port_sched #(.K(K), .B(B)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sel;
        int cred;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int req_v);
        checks++;
        if (act != req_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req_v, $time);
        end
    endtask

    task automatic push(input int sel, input int cred);
        exp_t e;
        e.sel  = sel;
        e.cred = cred;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [K-1:0] r, input logic [K-1:0] h,
                         input logic [K-1:0] t, input logic c);
        bus.req       = r;
        bus.head      = h;
        bus.tail      = t;
        bus.credit_in = c;
    endtask

    // Monitor: every transfer on the up-link is matched against the scoreboard.
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fire: got sel %0d expected no transfer (t=%0t)",
                         bus.out_sel, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("xfer sel=%0d grant=%b credits=%0d", bus.out_sel, bus.grant, bus.credits);
                chk("fire_sel", int'(bus.out_sel), e.sel);
                chk("fire_grant", int'(bus.grant), 1 << e.sel);
                chk("fire_credits", int'(bus.credits), e.cred);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, with requests present: nothing must be granted.
        drive(2'b11, 2'b11, 2'b11, 1'b0);
        repeat (2) cyc();
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_sel", int'(bus.out_sel), 0);
        chk("rst_credits", int'(bus.credits), 4);
        chk("rst_locked", int'(bus.locked), 0);
        chk("rst_err", int'(bus.err), 0);

        // Single-flit packets on both children: alternate grants, drain credits.
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(i % 2, 4 - i);
            cyc();
        end
        #1;
        chk("nocred_grant", int'(bus.grant), 0);
        chk("nocred_credits", int'(bus.credits), 0);
        drive(2'b00, 2'b00, 2'b00, 1'b1);
        repeat (4) cyc();
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        chk("refill_credits", int'(bus.credits), 4);

        // Three-flit packet from child 0 while child 1 keeps a head presented.
        drive(2'b11, 2'b11, 2'b10, 1'b0);
        push(0, 4);
        #1;
        chk("lock_before_head", int'(bus.locked), 0);
        cyc();
        chk("lock_after_head", int'(bus.locked), 1);
        drive(2'b11, 2'b10, 2'b10, 1'b0);
        push(0, 3);
        cyc();
        drive(2'b11, 2'b10, 2'b11, 1'b0);
        push(0, 2);
        chk("lock_at_tail", int'(bus.locked), 1);
        cyc();
        chk("lock_after_tail", int'(bus.locked), 0);
        drive(2'b11, 2'b11, 2'b11, 1'b0);
        push(1, 1);
        cyc();
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        chk("pkt_credits", int'(bus.credits), 0);
        chk("pkt_err", int'(bus.err), 0);

        // Lock held across a zero-credit stall.
        bus.credit_in = 1'b1;
        cyc();
        drive(2'b01, 2'b01, 2'b00, 1'b0);
        push(0, 1);
        cyc();
        drive(2'b01, 2'b00, 2'b00, 1'b0);
        #1;
        chk("stall_grant", int'(bus.grant), 0);
        chk("stall_locked", int'(bus.locked), 1);
        cyc();
        bus.credit_in = 1'b1;
        #1;
        chk("stall_grant2", int'(bus.grant), 0);
        cyc();
        drive(2'b01, 2'b00, 2'b01, 1'b0);
        chk("stall_credit_back", int'(bus.credits), 1);
        push(0, 1);
        cyc();
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        chk("stall_end_locked", int'(bus.locked), 0);
        chk("stall_end_credits", int'(bus.credits), 0);

        // Fire and credit return together leave the count unchanged.
        bus.credit_in = 1'b1;
        repeat (2) cyc();
        drive(2'b10, 2'b10, 2'b10, 1'b1);
        push(1, 2);
        cyc();
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        chk("both_credits", int'(bus.credits), 2);
        bus.credit_in = 1'b1;
        repeat (2) cyc();
        chk("full_credits", int'(bus.credits), 4);
        chk("full_err", int'(bus.err), 0);
        cyc();
        bus.credit_in = 1'b0;
        chk("ovf_credits", int'(bus.credits), 4);
        chk("ovf_err", int'(bus.err), 1);
        cyc();
        chk("ovf_err_sticky", int'(bus.err), 1);

        // Reset mid-packet: owner 1, one credit left.
        drive(2'b10, 2'b10, 2'b00, 1'b0);
        push(1, 4);
        cyc();
        drive(2'b10, 2'b00, 2'b00, 1'b0);
        push(1, 3);
        cyc();
        push(1, 2);
        cyc();
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        chk("pre_rst_credits", int'(bus.credits), 1);
        chk("pre_rst_locked", int'(bus.locked), 1);
        cyc();
        drive(2'b10, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_locked", int'(bus.locked), 0);
        chk("midrst_credits", int'(bus.credits), 4);
        chk("midrst_grant", int'(bus.grant), 0);
        chk("midrst_err", int'(bus.err), 0);
        cyc();
        rst_n = 1'b1;

        // Body flit in IDLE from child 1 is an error; child 0's head still wins.
        drive(2'b11, 2'b01, 2'b01, 1'b0);
        push(0, 4);
        #1;
        chk("body_idle_grant", int'(bus.grant), 1);
        cyc();
        chk("body_idle_err", int'(bus.err), 1);
        drive(2'b01, 2'b00, 2'b00, 1'b0);
        #1;
        chk("body_idle_nogrant", int'(bus.grant), 0);
        cyc();
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        repeat (3) cyc();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
